// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and constants for the PLL lock sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLLRST,
        WAITLOCK,
        STABLE,
        RUN,
        FAIL
    } pll_seq_state_t;

    localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer, async active-low reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock qualification with timeout/retry,
// and system reset release on the refclk domain.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 1048576,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RST_LOAD     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LOAD  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic lock_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    pll_seq_state_t  state_d, state_q;
    logic [CW-1:0]   cnt_d, cnt_q;
    logic [3:0]      retry_d, retry_q;
    logic [7:0]      loss_d, loss_q;
    logic            pll_rst_d, pll_rst_q;
    logic            sys_rst_d, sys_rst_q;
    logic            ready_d, ready_q;
    logic            fail_d, fail_q;
    logic [3:0]      retry_inc;

    assign retry_inc = retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (force_relock) begin
            state_d = PLLRST;
            cnt_d   = RST_LOAD;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                PLLRST: begin
                    if (cnt_q == '0) begin
                        state_d = WAITLOCK;
                        cnt_d   = TIMEOUT_LOAD;
                    end
                end
                WAITLOCK: begin
                    // A lock seen on the timeout cycle still counts as a lock.
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = STABLE_LOAD;
                    end else if (cnt_q == '0) begin
                        retry_d = retry_inc;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_d = FAIL;
                        end else begin
                            state_d = PLLRST;
                            cnt_d   = RST_LOAD;
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAITLOCK;
                        cnt_d   = TIMEOUT_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = PLLRST;
                        cnt_d   = RST_LOAD;
                        retry_d = 4'd0;
                        if (loss_q != LOCK_LOSS_MAX) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = PLLRST;
                    cnt_d   = RST_LOAD;
                end
            endcase
        end

        // Outputs decode the next state so they change on the same edge as the state.
        pll_rst_d = (state_d == PLLRST);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLLRST;
            cnt_q     <= RST_LOAD;
            retry_q   <= 4'd0;
            loss_q    <= 8'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT       (100),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (3)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .force_relock  (force_relock),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic cyc();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts the current sample plus following cycles while pll_rst is high.
    task automatic count_high(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 1000) begin
            n++;
            cyc();
        end
    endtask

    // Counts cycles with pll_rst low, stopping at the next pulse or at FAIL.
    task automatic count_low(output int n);
        n = 0;
        while (pll_rst === 1'b0 && fail === 1'b0 && n < 1000) begin
            n++;
            cyc();
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pll_rst"}, pll_rst, 1);
        chk({tag, "_sys_rst"}, sys_rst, 1);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_retry"}, retry_cnt, 0);
        chk({tag, "_loss"}, lock_loss_cnt, 0);
    endtask

    initial begin
        int n;
        int rel;
        int e;
        int w;
        int to_err;
        int early;

        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        repeat (3) cyc();
        chk_reset_values("reset");

        // Clean lock
        rst_n = 1'b1;
        count_high(n);
        chk("clean_pll_rst_len", n, 4);
        repeat (16) cyc();
        pll_locked = 1'b1;
        rel = 1;
        while (sys_rst === 1'b1 && rel < 200) begin
            cyc();
            rel++;
        end
        chk("clean_release_cycles", rel, 12);
        chk("clean_ready", ready, 1);
        chk("clean_retry", retry_cnt, 0);
        chk("clean_pll_rst_low", pll_rst, 0);

        // Loss in RUN
        pll_locked = 1'b0;
        e = 0;
        while (sys_rst === 1'b0 && e < 10) begin
            cyc();
            e++;
        end
        chk("loss_sys_rst_within_3", (e <= 3), 1);
        chk("loss_pll_rst", pll_rst, 1);
        chk("loss_ready", ready, 0);
        chk("loss_count_1", lock_loss_cnt, 1);

        to_err = 0;
        for (int k = 0; k < 299; k++) begin
            pll_locked = 1'b1;
            w = 0;
            while (ready !== 1'b1 && w < 200) begin
                cyc();
                w++;
            end
            if (w >= 200) to_err++;
            pll_locked = 1'b0;
            w = 0;
            while (sys_rst !== 1'b1 && w < 10) begin
                cyc();
                w++;
            end
            if (w >= 10) to_err++;
            if (k == 0) chk("loss_count_2", lock_loss_cnt, 2);
        end
        chk("loss_loop_timeouts", to_err, 0);
        chk("loss_count_saturated", lock_loss_cnt, 255);

        // Retry then fail, lock held low
        count_high(n);
        chk("retry_pulse1_len", n, 4);
        count_low(n);
        chk("retry_wait1_len", n, 100);
        chk("retry_cnt_1", retry_cnt, 1);
        count_high(n);
        chk("retry_pulse2_len", n, 4);
        count_low(n);
        chk("retry_wait2_len", n, 100);
        chk("retry_cnt_2", retry_cnt, 2);
        count_high(n);
        chk("retry_pulse3_len", n, 4);
        count_low(n);
        chk("retry_wait3_len", n, 100);
        chk("retry_cnt_3", retry_cnt, 3);
        chk("fail_flag", fail, 1);
        chk("fail_pll_rst", pll_rst, 0);
        chk("fail_sys_rst", sys_rst, 1);
        repeat (10) cyc();
        chk("fail_hold", fail, 1);

        force_relock = 1'b1;
        cyc();
        force_relock = 1'b0;
        chk("relock_pll_rst", pll_rst, 1);
        chk("relock_sys_rst", sys_rst, 1);
        chk("relock_fail_clear", fail, 0);
        chk("relock_retry_clear", retry_cnt, 0);
        count_high(n);
        chk("relock_pulse_len", n, 4);

        // Force on the timeout cycle of WAITLOCK
        repeat (99) cyc();
        chk("timeout_edge_waiting", pll_rst, 0);
        force_relock = 1'b1;
        cyc();
        force_relock = 1'b0;
        chk("timeout_force_pll_rst", pll_rst, 1);
        chk("timeout_force_retry", retry_cnt, 0);
        chk("timeout_force_fail", fail, 0);

        // Glitchy lock
        count_high(n);
        chk("glitch_pulse_len", n, 4);
        early = 0;
        pll_locked = 1'b1;
        repeat (5) begin
            cyc();
            if (sys_rst !== 1'b1) early++;
        end
        pll_locked = 1'b0;
        repeat (2) begin
            cyc();
            if (sys_rst !== 1'b1) early++;
        end
        pll_locked = 1'b1;
        rel = 1;
        while (sys_rst === 1'b1 && rel < 200) begin
            cyc();
            rel++;
        end
        chk("glitch_no_early_release", early, 0);
        chk("glitch_release_cycles", rel, 12);
        chk("glitch_retry", retry_cnt, 0);
        chk("glitch_ready", ready, 1);

        // Async reset between edges while in RUN
        chk("async_pre_ready", ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async");
        rst_n = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
